bpu_update_ctrl: RTL and testbench

Sequences all writes into the branch prediction cache, which is read by the fetch-side next-PC logic. It runs the post-reset and flush-all invalidation sweep. It also buffers branch/jump resolutions from execute in a small FIFO and performs read-modify-write updates of each entry's tag, target and 2-bit counter. It is the single write port owner of the prediction cache and sits between the execute stage and the cache array.

---
 rtl/bpu_update_ctrl.sv | 262 ++++++++++++++++++++++++++
 tb/tb_bpu_update_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpu_update_ctrl.sv
// Branch prediction cache update controller: sole writer of the prediction
// cache. Runs the invalidation sweep after reset / flush-all and applies
// queued execute-stage resolutions as read-modify-write updates.
module bpu_update_ctrl #(
    parameter int unsigned CACHE_SIZE = 16,
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned FIFO_DEPTH = 2,
    localparam int unsigned IDX_W     = $clog2(CACHE_SIZE),
    localparam int unsigned TAG_W     = WIDTH - IDX_W - 2
) (
    input  logic             clk,
    input  logic             rst,
    // resolution input from execute
    input  logic             upd_valid_i,
    input  logic [WIDTH-1:0] upd_pc_i,
    input  logic [WIDTH-1:0] upd_target_i,
    input  logic             upd_taken_i,
    output logic             upd_ready_o,
    input  logic             flush_all_i,
    // cache read port
    output logic             rd_en_o,
    output logic [IDX_W-1:0] rd_idx_o,
    input  logic             rd_valid_i,
    input  logic [TAG_W-1:0] rd_tag_i,
    input  logic [1:0]       rd_ctr_i,
    input  logic [WIDTH-1:0] rd_target_i,
    // cache write port
    output logic             wr_en_o,
    output logic [IDX_W-1:0] wr_idx_o,
    output logic             wr_valid_o,
    output logic [TAG_W-1:0] wr_tag_o,
    output logic [WIDTH-1:0] wr_target_o,
    output logic [1:0]       wr_ctr_o,
    output logic             busy_o
);

    // Word-aligned PCs: only pc[WIDTH-1:2] is carried through the pipeline.
    localparam int unsigned PC_W  = WIDTH - 2;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_IDLE   = 2'd1,
        S_LOOKUP = 2'd2,
        S_WRITE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [IDX_W-1:0] sweep_cnt;
    logic             sweep_last;

    // resolution FIFO
    logic [PC_W-1:0]  fifo_pc     [FIFO_DEPTH];
    logic [WIDTH-1:0] fifo_target [FIFO_DEPTH];
    logic             fifo_taken  [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic [PC_W-1:0]  head_pc;

    // working entry under lookup
    logic [PC_W-1:0]  work_pc;
    logic [WIDTH-1:0] work_target;
    logic             work_taken;
    logic [IDX_W-1:0] work_idx;
    logic [TAG_W-1:0] work_tag;

    // lookup decision
    logic             hit;
    logic             need_write;
    logic [1:0]       ctr_inc;
    logic [1:0]       ctr_dec;
    logic [1:0]       ctr_new;
    logic [WIDTH-1:0] target_new;

    // next values of the registered outputs
    logic             wr_en_n;
    logic [IDX_W-1:0] wr_idx_n;
    logic             wr_valid_n;
    logic [TAG_W-1:0] wr_tag_n;
    logic [WIDTH-1:0] wr_target_n;
    logic [1:0]       wr_ctr_n;
    logic             busy_n;

    // Low PC bits are always zero for aligned instructions and are not kept.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^upd_pc_i[1:0];

    assign sweep_last = (sweep_cnt == IDX_W'(CACHE_SIZE - 1));
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign head_pc    = fifo_pc[rd_ptr];
    assign push       = upd_valid_i & upd_ready_o;
    assign pop        = (state == S_IDLE) & ~fifo_empty & ~flush_all_i;
    assign work_idx   = work_pc[IDX_W-1:0];
    assign work_tag   = work_pc[PC_W-1:IDX_W];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flush-all overrides every state
    always_comb begin
        state_next = state;
        if (flush_all_i) begin
            state_next = S_INIT;
        end else begin
            case (state)
                S_INIT:   if (sweep_last) state_next = S_IDLE;
                S_IDLE:   if (!fifo_empty) state_next = S_LOOKUP;
                S_LOOKUP: state_next = need_write ? S_WRITE : S_IDLE;
                S_WRITE:  state_next = S_IDLE;
                default:  state_next = S_INIT;
            endcase
        end
    end

    // Lookup decode: hit detection and saturating counter update
    always_comb begin
        hit        = rd_valid_i & (rd_tag_i == work_tag);
        need_write = hit | work_taken;
        ctr_inc    = (rd_ctr_i == 2'b11) ? 2'b11 : rd_ctr_i + 2'd1;
        ctr_dec    = (rd_ctr_i == 2'b00) ? 2'b00 : rd_ctr_i - 2'd1;
        ctr_new    = 2'b10;
        target_new = work_target;
        if (hit) begin
            ctr_new = work_taken ? ctr_inc : ctr_dec;
            if (!work_taken) begin
                target_new = rd_target_i;
            end
        end
    end

    // Output logic: combinational read/ready plus next values of write port
    always_comb begin
        upd_ready_o = ~fifo_full & ~flush_all_i;
        rd_en_o     = (state == S_IDLE) & ~fifo_empty;
        rd_idx_o    = head_pc[IDX_W-1:0];
        wr_en_n     = 1'b0;
        wr_idx_n    = '0;
        wr_valid_n  = 1'b0;
        wr_tag_n    = '0;
        wr_target_n = '0;
        wr_ctr_n    = '0;
        busy_n      = 1'b0;
        if (flush_all_i) begin
            // restart sweep at index 0, cancelling any pending update write
            wr_en_n = 1'b1;
            busy_n  = 1'b1;
        end else begin
            case (state)
                S_INIT: begin
                    if (!sweep_last) begin
                        wr_en_n  = 1'b1;
                        wr_idx_n = sweep_cnt + IDX_W'(1);
                        busy_n   = 1'b1;
                    end
                end
                S_LOOKUP: begin
                    if (need_write) begin
                        wr_en_n     = 1'b1;
                        wr_idx_n    = work_idx;
                        wr_valid_n  = 1'b1;
                        wr_tag_n    = work_tag;
                        wr_target_n = target_new;
                        wr_ctr_n    = ctr_new;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered write port and busy flag; reset presents sweep index 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en_o     <= 1'b1;
            wr_idx_o    <= '0;
            wr_valid_o  <= 1'b0;
            wr_tag_o    <= '0;
            wr_target_o <= '0;
            wr_ctr_o    <= '0;
            busy_o      <= 1'b1;
        end else begin
            wr_en_o     <= wr_en_n;
            wr_idx_o    <= wr_idx_n;
            wr_valid_o  <= wr_valid_n;
            wr_tag_o    <= wr_tag_n;
            wr_target_o <= wr_target_n;
            wr_ctr_o    <= wr_ctr_n;
            busy_o      <= busy_n;
        end
    end

    // Sweep counter: advances only while sweeping, cleared otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sweep_cnt <= '0;
        end else if (flush_all_i || state != S_INIT) begin
            sweep_cnt <= '0;
        end else begin
            sweep_cnt <= sweep_cnt + IDX_W'(1);
        end
    end

    // FIFO pointers and occupancy; flush-all empties the queue
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (flush_all_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]     <= upd_pc_i[WIDTH-1:2];
            fifo_target[wr_ptr] <= upd_target_i;
            fifo_taken[wr_ptr]  <= upd_taken_i;
        end
    end

    // Working register: captures the FIFO head as it is popped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            work_pc     <= '0;
            work_target <= '0;
            work_taken  <= 1'b0;
        end else if (pop) begin
            work_pc     <= head_pc;
            work_target <= fifo_target[rd_ptr];
            work_taken  <= fifo_taken[rd_ptr];
        end
    end

endmodule

// File: tb/tb_bpu_update_ctrl.sv
// Directed bench for bpu_update_ctrl: vector table for single updates plus
// hand sequences for pipelining, backpressure and flush-all behaviour.
module tb_bpu_update_ctrl;

    localparam int unsigned W     = 32;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned TAG_W = 26;

    logic             clk;
    logic             rst;
    logic             upd_valid_i;
    logic [W-1:0]     upd_pc_i;
    logic [W-1:0]     upd_target_i;
    logic             upd_taken_i;
    logic             upd_ready_o;
    logic             flush_all_i;
    logic             rd_en_o;
    logic [IDX_W-1:0] rd_idx_o;
    logic             rd_valid_i;
    logic [TAG_W-1:0] rd_tag_i;
    logic [1:0]       rd_ctr_i;
    logic [W-1:0]     rd_target_i;
    logic             wr_en_o;
    logic [IDX_W-1:0] wr_idx_o;
    logic             wr_valid_o;
    logic [TAG_W-1:0] wr_tag_o;
    logic [W-1:0]     wr_target_o;
    logic [1:0]       wr_ctr_o;
    logic             busy_o;

    int checks = 0;
    int passed = 0;

    bpu_update_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .upd_valid_i  (upd_valid_i),
        .upd_pc_i     (upd_pc_i),
        .upd_target_i (upd_target_i),
        .upd_taken_i  (upd_taken_i),
        .upd_ready_o  (upd_ready_o),
        .flush_all_i  (flush_all_i),
        .rd_en_o      (rd_en_o),
        .rd_idx_o     (rd_idx_o),
        .rd_valid_i   (rd_valid_i),
        .rd_tag_i     (rd_tag_i),
        .rd_ctr_i     (rd_ctr_i),
        .rd_target_i  (rd_target_i),
        .wr_en_o      (wr_en_o),
        .wr_idx_o     (wr_idx_o),
        .wr_valid_o   (wr_valid_o),
        .wr_tag_o     (wr_tag_o),
        .wr_target_o  (wr_target_o),
        .wr_ctr_o     (wr_ctr_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string            name;
        logic [W-1:0]     pc;
        logic [W-1:0]     tgt;
        logic             taken;
        logic             rv;
        logic [TAG_W-1:0] rtag;
        logic [1:0]       rctr;
        logic [W-1:0]     rtgt;
        logic             wr;
        logic [IDX_W-1:0] idx;
        logic [TAG_W-1:0] tag;
        logic [W-1:0]     wtgt;
        logic [1:0]       ctr;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive_upd(input logic v, input logic [W-1:0] pc,
                             input logic [W-1:0] tgt, input logic tk);
        upd_valid_i  = v;
        upd_pc_i     = pc;
        upd_target_i = tgt;
        upd_taken_i  = tk;
    endtask

    task automatic drive_rd(input logic v, input logic [TAG_W-1:0] tag,
                            input logic [1:0] ctr, input logic [W-1:0] tgt);
        rd_valid_i  = v;
        rd_tag_i    = tag;
        rd_ctr_i    = ctr;
        rd_target_i = tgt;
    endtask

    int unsigned acc_n;
    int unsigned got_idx [$];
    logic [W-1:0] got_tgt [$];

    initial begin
        rst = 1'b0;
        flush_all_i = 1'b0;
        drive_upd(1'b0, '0, '0, 1'b0);
        drive_rd(1'b0, '0, '0, '0);

        //          name          pc            tgt           tk  rv  rtag          rctr   rtgt          wr  idx  tag           wtgt          ctr
        vecs[0] = '{"miss_taken", 32'h0000_0104, 32'h0000_0200, 1, 0, 26'h0,        2'd0, 32'h0,        1, 4'd1,  26'h4,        32'h0000_0200, 2'd2};
        vecs[1] = '{"hit_sat_hi", 32'h0000_0104, 32'h0000_0300, 1, 1, 26'h4,        2'd3, 32'h0000_0200, 1, 4'd1,  26'h4,        32'h0000_0300, 2'd3};
        vecs[2] = '{"hit_sat_lo", 32'h0000_0104, 32'h0000_0300, 0, 1, 26'h4,        2'd0, 32'h0000_0200, 1, 4'd1,  26'h4,        32'h0000_0200, 2'd0};
        vecs[3] = '{"hit_inc",    32'h0000_0A3C, 32'h0000_1000, 1, 1, 26'h28,       2'd1, 32'h0000_0800, 1, 4'd15, 26'h28,       32'h0000_1000, 2'd2};
        vecs[4] = '{"hit_dec",    32'h8000_0010, 32'h0000_4444, 0, 1, 26'h200_0000, 2'd2, 32'h0000_ABC0, 1, 4'd4,  26'h200_0000, 32'h0000_ABC0, 2'd1};
        vecs[5] = '{"tag_mis_tk", 32'h0000_0104, 32'h0000_0500, 1, 1, 26'h5,        2'd3, 32'h0000_0900, 1, 4'd1,  26'h4,        32'h0000_0500, 2'd2};
        vecs[6] = '{"miss_nt",    32'h0000_0050, 32'h0000_0600, 0, 0, 26'h0,        2'd0, 32'h0,        0, 4'd4,  26'h0,        32'h0,        2'd0};
        vecs[7] = '{"tag_mis_nt", 32'h0000_0070, 32'h0000_0600, 0, 1, 26'h0,        2'd3, 32'h0000_0100, 0, 4'd12, 26'h0,        32'h0,        2'd0};

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 64'(busy_o), 64'd1);
        chk("rst_ready", 64'(upd_ready_o), 64'd1);
        chk("rst_rd_en", 64'(rd_en_o), 64'd0);
        chk("rst_wr_en", 64'(wr_en_o), 64'd1);
        chk("rst_wr_idx", 64'(wr_idx_o), 64'd0);
        chk("rst_wr_valid", 64'(wr_valid_o), 64'd0);
        chk("rst_wr_fields", 64'({wr_tag_o, wr_target_o, wr_ctr_o} != '0), 64'd0);

        // post-reset sweep: 16 cycles, idx 0..15
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            chk("sweep_wr_en", 64'(wr_en_o), 64'd1);
            chk("sweep_idx", 64'(wr_idx_o), 64'(k));
            chk("sweep_valid", 64'(wr_valid_o), 64'd0);
            chk("sweep_busy", 64'(busy_o), 64'd1);
        end
        @(negedge clk);
        #1;
        chk("sweep_end_busy", 64'(busy_o), 64'd0);
        chk("sweep_end_wr_en", 64'(wr_en_o), 64'd0);
        chk("sweep_end_rd_en", 64'(rd_en_o), 64'd0);

        // single updates from an idle, empty controller
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive_upd(1'b1, vecs[i].pc, vecs[i].tgt, vecs[i].taken);
            #1;
            chk({vecs[i].name, "_ready"}, 64'(upd_ready_o), 64'd1);
            @(negedge clk);
            drive_upd(1'b0, '0, '0, 1'b0);
            #1;
            chk({vecs[i].name, "_rd_en"}, 64'(rd_en_o), 64'd1);
            chk({vecs[i].name, "_rd_idx"}, 64'(rd_idx_o), 64'(vecs[i].idx));
            @(negedge clk);
            drive_rd(vecs[i].rv, vecs[i].rtag, vecs[i].rctr, vecs[i].rtgt);
            #1;
            chk({vecs[i].name, "_lookup_wr_en"}, 64'(wr_en_o), 64'd0);
            chk({vecs[i].name, "_lookup_rd_en"}, 64'(rd_en_o), 64'd0);
            @(negedge clk);
            drive_rd(1'b0, '0, '0, '0);
            #1;
            chk({vecs[i].name, "_wr_en"}, 64'(wr_en_o), 64'(vecs[i].wr));
            if (vecs[i].wr) begin
                chk({vecs[i].name, "_wr_idx"}, 64'(wr_idx_o), 64'(vecs[i].idx));
                chk({vecs[i].name, "_wr_valid"}, 64'(wr_valid_o), 64'd1);
                chk({vecs[i].name, "_wr_tag"}, 64'(wr_tag_o), 64'(vecs[i].tag));
                chk({vecs[i].name, "_wr_target"}, 64'(wr_target_o), 64'(vecs[i].wtgt));
                chk({vecs[i].name, "_wr_ctr"}, 64'(wr_ctr_o), 64'(vecs[i].ctr));
            end
            @(negedge clk);
            #1;
            chk({vecs[i].name, "_after_wr_en"}, 64'(wr_en_o), 64'd0);
        end

        // two back-to-back no-write misses: reads issue 2 cycles apart
        @(negedge clk);
        drive_upd(1'b1, 32'h0000_0050, 32'h0, 1'b0);
        #1;
        @(negedge clk);
        drive_upd(1'b1, 32'h0000_0060, 32'h0, 1'b0);
        #1;
        chk("nt2_rd0_en", 64'(rd_en_o), 64'd1);
        chk("nt2_rd0_idx", 64'(rd_idx_o), 64'd4);
        @(negedge clk);
        drive_upd(1'b0, '0, '0, 1'b0);
        #1;
        chk("nt2_lookup_rd_en", 64'(rd_en_o), 64'd0);
        chk("nt2_lookup_wr_en", 64'(wr_en_o), 64'd0);
        @(negedge clk);
        #1;
        chk("nt2_rd1_en", 64'(rd_en_o), 64'd1);
        chk("nt2_rd1_idx", 64'(rd_idx_o), 64'd8);
        chk("nt2_rd1_wr_en", 64'(wr_en_o), 64'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            chk("nt2_tail_wr_en", 64'(wr_en_o), 64'd0);
            chk("nt2_tail_rd_en", 64'(rd_en_o), 64'd0);
        end

        // backpressure: upd_valid held for 6 cycles, writes retire in order
        acc_n = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            drive_upd(1'b1, 32'h0000_0100 + 32'(acc_n * 4), 32'h0000_1000 + 32'(acc_n * 16), 1'b1);
            #1;
            if (c == 3 || c == 4) chk("bp_ready_low", 64'(upd_ready_o), 64'd0);
            if (upd_ready_o) acc_n++;
            if (wr_en_o) begin
                got_idx.push_back(int'(wr_idx_o));
                got_tgt.push_back(wr_target_o);
            end
        end
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            drive_upd(1'b0, '0, '0, 1'b0);
            #1;
            if (wr_en_o) begin
                got_idx.push_back(int'(wr_idx_o));
                got_tgt.push_back(wr_target_o);
            end
        end
        chk("bp_accepted", 64'(acc_n), 64'd4);
        chk("bp_writes", 64'(got_idx.size()), 64'd4);
        for (int i = 0; i < got_idx.size() && i < 4; i++) begin
            chk("bp_order_idx", 64'(got_idx[i]), 64'(i));
            chk("bp_order_tgt", 64'(got_tgt[i]), 64'(32'h0000_1000 + 32'(i * 16)));
        end

        // flush-all in LOOKUP with one entry queued and a simultaneous push
        @(negedge clk);
        drive_upd(1'b1, 32'h0000_0104, 32'h0000_0700, 1'b1);
        #1;
        @(negedge clk);
        drive_upd(1'b1, 32'h0000_0108, 32'h0000_0704, 1'b1);
        #1;
        chk("fl_rd_en", 64'(rd_en_o), 64'd1);
        chk("fl_rd_idx", 64'(rd_idx_o), 64'd1);
        @(negedge clk);
        drive_upd(1'b1, 32'h0000_010C, 32'h0000_0708, 1'b1);
        flush_all_i = 1'b1;
        #1;
        chk("fl_ready_low", 64'(upd_ready_o), 64'd0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            drive_upd(1'b0, '0, '0, 1'b0);
            flush_all_i = 1'b0;
            #1;
            chk("fl_sweep_wr_en", 64'(wr_en_o), 64'd1);
            chk("fl_sweep_idx", 64'(wr_idx_o), 64'(k));
            chk("fl_sweep_valid", 64'(wr_valid_o), 64'd0);
            chk("fl_sweep_target", 64'(wr_target_o), 64'd0);
            chk("fl_sweep_rd_en", 64'(rd_en_o), 64'd0);
            chk("fl_sweep_busy", 64'(busy_o), 64'd1);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk("fl_after_busy", 64'(busy_o), 64'd0);
            chk("fl_after_rd_en", 64'(rd_en_o), 64'd0);
            chk("fl_after_wr_en", 64'(wr_en_o), 64'd0);
        end

        // flush-all during the sweep restarts it; pushes accepted while sweeping
        @(negedge clk);
        flush_all_i = 1'b1;
        #1;
        chk("fi_ready_low", 64'(upd_ready_o), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            flush_all_i = (k == 2);
            #1;
            chk("fi_first_idx", 64'(wr_idx_o), 64'(k));
        end
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            flush_all_i = 1'b0;
            drive_upd(k == 1, 32'h0000_0104, 32'h0000_0240, 1'b1);
            #1;
            chk("fi_restart_idx", 64'(wr_idx_o), 64'(k));
            chk("fi_restart_busy", 64'(busy_o), 64'd1);
            if (k == 1) chk("fi_init_ready", 64'(upd_ready_o), 64'd1);
        end
        @(negedge clk);
        drive_upd(1'b0, '0, '0, 1'b0);
        #1;
        chk("fi_idle_busy", 64'(busy_o), 64'd0);
        chk("fi_idle_rd_en", 64'(rd_en_o), 64'd1);
        chk("fi_idle_rd_idx", 64'(rd_idx_o), 64'd1);
        @(negedge clk);
        #1;
        chk("fi_lookup_rd_en", 64'(rd_en_o), 64'd0);
        @(negedge clk);
        #1;
        chk("fi_wr_en", 64'(wr_en_o), 64'd1);
        chk("fi_wr_idx", 64'(wr_idx_o), 64'd1);
        chk("fi_wr_valid", 64'(wr_valid_o), 64'd1);
        chk("fi_wr_tag", 64'(wr_tag_o), 64'd4);
        chk("fi_wr_target", 64'(wr_target_o), 64'h240);
        chk("fi_wr_ctr", 64'(wr_ctr_o), 64'd2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
